// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver (digit count, glyphs, blank/off patterns).
package seg_pkg;
  typedef logic [6:0] seg_t;
  localparam int NUM_DIGITS = 4;
  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: hex nibble (nib_i) to active-low {a..g} glyph (seg_o), purely combinational.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed hex display; clk/rst(async, active-low), number+load in; anode_activate, led_out, frame_done out; SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           number,
  input  logic                  load,
  output logic [NUM_DIGITS-1:0] anode_activate,
  output seg_t                  led_out,
  output logic                  frame_done
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [15:0] shown_q, shown_d, pend_q, pend_d;
  logic pflag_q, pflag_d;
  logic wrap;
  logic [1:0] sel;
  logic [3:0] nib, an_d;
  seg_t glyph, led_d;
  seg_hex_decode u_dec (.nib_i(nib), .seg_o(glyph));
  // shown only changes at the frame boundary so a frame is never mixed
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    wrap = &cnt_q;
    sel = cnt_q[DIV_W-1 -: 2];
    shown_d = wrap ? (load ? number : (pflag_q ? pend_q : shown_q)) : shown_q;
    pend_d = (load && !wrap) ? number : pend_q;
    pflag_d = !wrap && (load || pflag_q);
    nib = shown_q[{sel, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    an_d = (sel != 2'd0 && (shown_q >> {sel, 2'b00}) == 16'd0) ? ANODE_OFF : ~(4'b0001 << sel);
    led_d = (sel != 2'd0 && (shown_q >> {sel, 2'b00}) == 16'd0) ? SEG_BLANK : glyph;
`else
    an_d = ~(4'b0001 << sel);
    led_d = glyph;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      shown_q <= '0;
      pend_q <= '0;
      pflag_q <= 1'b0;
      anode_activate <= ANODE_OFF;
      led_out <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      shown_q <= shown_d;
      pend_q <= pend_d;
      pflag_q <= pflag_d;
      anode_activate <= an_d;
      led_out <= led_d;
      frame_done <= wrap;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed and random checks of seg_scan_driver (DIV_W=4) against a frame-level reference model.
module tb_seg_scan_driver;
  logic clk = 1'b0, rst = 1'b0, load = 1'b0, frame_done;
  logic [15:0] number = '0;
  logic [3:0] anode_activate;
  logic [6:0] led_out;
  int n_chk = 0, n_fail = 0;
  int m_cnt = 0;
  logic [15:0] m_shown = '0, m_pend = '0;
  bit m_pflag = 1'b0;
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_led = 7'h7F;
  logic e_fd = 1'b0;
  logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  seg_scan_driver #(.DIV_W(4)) dut (
    .clk(clk), .rst(rst), .number(number), .load(load),
    .anode_activate(anode_activate), .led_out(led_out), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic ld, input logic [15:0] n);
    int sel;
    logic [3:0] nib;
    bit blank;
    load = ld;
    number = n;
    if (!rst) begin
      e_an = 4'hF; e_led = 7'h7F; e_fd = 1'b0;
      m_cnt = 0; m_shown = '0; m_pend = '0; m_pflag = 1'b0;
    end else begin
      sel = m_cnt / 4;
      nib = 4'(m_shown >> (4 * sel));
      blank = 1'b0;
`ifdef SEG_LZB_EN
      blank = (sel != 0) && ((m_shown >> (4 * sel)) == 0);
`endif
      e_an = blank ? 4'hF : 4'(4'hF ^ (1 << sel));
      e_led = blank ? 7'h7F : glyph_tab[nib];
      e_fd = (m_cnt == 15);
      if (m_cnt == 15) begin
        if (ld) m_shown = n;
        else if (m_pflag) m_shown = m_pend;
        m_pflag = 1'b0;
      end else if (ld) begin
        m_pend = n;
        m_pflag = 1'b1;
      end
      m_cnt = (m_cnt + 1) % 16;
    end
    @(negedge clk);
    chk("anode", {12'd0, anode_activate}, {12'd0, e_an});
    chk("led", {9'd0, led_out}, {9'd0, e_led});
    chk("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
  endtask
  task automatic go_to(input int k);
    while (m_cnt != k) cycle(1'b0, 16'h0);
  endtask
  initial begin
    repeat (3) cycle(1'b0, 16'h0);
    rst = 1'b1;
    repeat (40) cycle(1'b0, 16'h0);
    go_to(5); cycle(1'b1, 16'hA123);
    repeat (40) cycle(1'b0, 16'h0);
    go_to(3); cycle(1'b1, 16'h1111);
    go_to(9); cycle(1'b1, 16'h2222);
    repeat (40) cycle(1'b0, 16'h0);
    go_to(15); cycle(1'b1, 16'h00C5);
    repeat (36) cycle(1'b0, 16'h0);
    go_to(7); cycle(1'b1, 16'h0005);
    repeat (36) cycle(1'b0, 16'h0);
    go_to(7); cycle(1'b1, 16'h0000);
    repeat (36) cycle(1'b0, 16'h0);
    go_to(3); cycle(1'b1, 16'hBEEF);
    go_to(10);
    rst = 1'b0;
    #1;
    chk("async_anode", {12'd0, anode_activate}, 16'h000F);
    chk("async_led", {9'd0, led_out}, 16'h007F);
    chk("async_fd", {15'd0, frame_done}, 16'h0000);
    repeat (3) cycle(1'b0, 16'h0);
    rst = 1'b1;
    repeat (40) cycle(1'b0, 16'h0);
    repeat (500) cycle($urandom_range(0, 7) == 0, 16'($urandom) >> $urandom_range(0, 15));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
